// File: rtl/onchip_mem_block_copier.sv
// rtl/onchip_mem_block_copier.sv - Avalon-MM word block copier through a chunk buffer
// Optional MEMCOPY_FILL_EN adds fill_mode/fill_pattern for pattern fills instead of copies.
module onchip_mem_block_copier #(
    parameter int ADDR_W     = 15,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
`ifdef MEMCOPY_FILL_EN
    input  logic              fill_mode,
    input  logic [31:0]       fill_pattern,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [CW-1:0]     chunk_q, chunk_d, cnt_q, cnt_d, outstanding_q, outstanding_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              fill_q, fill_d;
    logic [31:0]       pattern_q, pattern_d;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic              fill_req;
    logic [31:0]       pattern_req;
    logic              rd_accept, wr_accept, push;

`ifdef MEMCOPY_FILL_EN
    assign fill_req    = fill_mode;
    assign pattern_req = fill_pattern;
`else
    assign fill_req    = 1'b0;
    assign pattern_req = '0;
`endif

    function automatic logic [CW-1:0] chunk_of(input logic [LEN_W-1:0] r);
        if (r >= LEN_W'(FIFO_DEPTH)) return CW'(FIFO_DEPTH);
        return r[CW-1:0];
    endfunction

    assign busy           = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_WRITE);
    assign done           = (state_q == S_DONE);
    assign avm_read       = (state_q == S_READ);
    assign avm_write      = (state_q == S_WRITE);
    assign avm_byteenable = (avm_read || avm_write) ? 4'b1111 : 4'b0000;
    assign avm_address    = avm_read ? src_q : (avm_write ? dst_q : '0);
    assign avm_writedata  = avm_write ? (fill_q ? pattern_q : fifo_mem[rd_ptr_q]) : '0;

    assign rd_accept = avm_read && !avm_waitrequest;
    assign wr_accept = avm_write && !avm_waitrequest;
    // Data with no read outstanding is stale (e.g. from before a reset) and dropped.
    assign push      = avm_readdatavalid && (outstanding_q != '0);

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        remaining_d   = remaining_q;
        chunk_d       = chunk_q;
        cnt_d         = cnt_q;
        rd_ptr_d      = rd_ptr_q;
        fill_d        = fill_q;
        pattern_d     = pattern_q;
        outstanding_d = outstanding_q + CW'(rd_accept) - CW'(push);
        wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_d = S_DONE;
                    end else begin
                        src_d       = src_addr;
                        dst_d       = dst_addr;
                        remaining_d = length;
                        chunk_d     = chunk_of(length);
                        cnt_d       = '0;
                        fill_d      = fill_req;
                        pattern_d   = pattern_req;
                        state_d     = fill_req ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                if (rd_accept) begin
                    src_d = src_q + ADDR_W'(1);
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == chunk_q - CW'(1)) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (outstanding_d == '0) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wr_accept) begin
                    dst_d = dst_q + ADDR_W'(1);
                    cnt_d = cnt_q + CW'(1);
                    if (!fill_q) rd_ptr_d = rd_ptr_q + PW'(1);
                    if (cnt_q == chunk_q - CW'(1)) begin
                        cnt_d       = '0;
                        remaining_d = remaining_q - LEN_W'(chunk_q);
                        if (remaining_d == '0) begin
                            state_d = S_DONE;
                        end else begin
                            chunk_d = chunk_of(remaining_d);
                            state_d = fill_q ? S_WRITE : S_READ;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            remaining_q   <= '0;
            chunk_q       <= '0;
            cnt_q         <= '0;
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= 1'b0;
            pattern_q     <= '0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            remaining_q   <= remaining_d;
            chunk_q       <= chunk_d;
            cnt_q         <= cnt_d;
            outstanding_q <= outstanding_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_q        <= fill_d;
            pattern_q     <= pattern_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= avm_readdata;
    end
endmodule

// File: tb/tb_onchip_mem_block_copier.sv
// tb/tb_onchip_mem_block_copier.sv - self-checking bench with memory slave and transfer model
module tb_onchip_mem_block_copier;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [14:0] src_addr, dst_addr;
    logic [15:0] length;
`ifdef MEMCOPY_FILL_EN
    logic        fill_mode;
    logic [31:0] fill_pattern;
`endif
    logic        busy, done, avm_read, avm_write;
    logic [14:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata, avm_readdata;
    logic        avm_waitrequest, avm_readdatavalid;

    onchip_mem_block_copier dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
`ifdef MEMCOPY_FILL_EN
        .fill_mode(fill_mode), .fill_pattern(fill_pattern),
`endif
        .busy(busy), .done(done), .avm_address(avm_address),
        .avm_read(avm_read), .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] mem [0:32767];
    logic [14:0] exp_rd[$];
    logic [14:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    int rd_count, wr_count, done_count, busy_cycles, first_busy, done_cyc, t0;
    int stall_left = -1;
    bit stall_en = 0, inject_rdv = 0;
    bit pend_v = 0, prev_hold = 0;
    logic [31:0] pend_d;
    logic        prev_rd, prev_wr;
    logic [14:0] prev_addr;
    logic [31:0] prev_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Slave + monitor: drives slave inputs and checks outputs at the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_left = -1; pend_v = 0; prev_hold = 0;
            avm_readdatavalid = 0; avm_waitrequest = 0;
        end else begin
            if (inject_rdv) begin
                avm_readdatavalid = 1; avm_readdata = 32'hBAD0_BAD0; inject_rdv = 0;
            end else begin
                avm_readdatavalid = pend_v; avm_readdata = pend_v ? pend_d : 32'h0;
            end
            pend_v = 0;
            if (avm_read && avm_write) chk("rw_overlap", 32'(avm_read && avm_write), 32'h0);
            chk("byteenable", 32'(avm_byteenable), (avm_read || avm_write) ? 32'hF : 32'h0);
            if (prev_hold) begin
                chk("hold_read", 32'(avm_read), 32'(prev_rd));
                chk("hold_write", 32'(avm_write), 32'(prev_wr));
                chk("hold_addr", 32'(avm_address), 32'(prev_addr));
                chk("hold_wdata", avm_writedata, prev_wd);
            end
            if (done) begin done_count++; done_cyc = cyc; end
            if (busy) begin busy_cycles++; if (first_busy < 0) first_busy = cyc; end
            avm_waitrequest = 0;
            if (avm_read || avm_write) begin
                if (stall_left < 0) stall_left = stall_en ? int'($urandom_range(0, 3)) : 0;
                if (stall_left > 0) begin avm_waitrequest = 1; stall_left--; end
                else stall_left = -1;
            end
            if (avm_read && !avm_waitrequest) begin
                rd_count++;
                if (exp_rd.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_unexpected actual=%h required=no read", avm_address);
                end else chk("rd_addr", 32'(avm_address), 32'(exp_rd.pop_front()));
                pend_v = 1; pend_d = mem[avm_address];
            end
            if (avm_write && !avm_waitrequest) begin
                wr_count++;
                if (exp_wa.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wr_unexpected actual=%h required=no write", avm_address);
                end else begin
                    chk("wr_addr", 32'(avm_address), 32'(exp_wa.pop_front()));
                    chk("wr_data", avm_writedata, exp_wd.pop_front());
                end
                mem[avm_address] = avm_writedata;
            end
            prev_hold = (avm_read || avm_write) && avm_waitrequest;
            prev_rd = avm_read; prev_wr = avm_write; prev_addr = avm_address; prev_wd = avm_writedata;
        end
    end

    task automatic start_copy(input logic [14:0] s, input logic [14:0] d, input logic [15:0] n,
                              input logic f, input logic [31:0] pat);
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        for (int i = 0; i < int'(n); i++) begin
            if (!f) exp_rd.push_back(15'(s + i));
            exp_wa.push_back(15'(d + i));
            exp_wd.push_back(f ? pat : mem[15'(s + i)]);
        end
        rd_count = 0; wr_count = 0; done_count = 0; busy_cycles = 0; first_busy = -1; done_cyc = -1;
        @(posedge clk); #1;
        src_addr = s; dst_addr = d; length = n;
`ifdef MEMCOPY_FILL_EN
        fill_mode = f; fill_pattern = pat;
`endif
        start = 1; t0 = cyc;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_count == 0 && n < budget) begin @(posedge clk); n++; end
        if (done_count == 0) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=none required=done within %0d cycles", budget);
        end
        repeat (3) @(posedge clk);
        chk("rd_left", 32'(exp_rd.size()), 32'h0);
        chk("wr_left", 32'(exp_wa.size()), 32'h0);
    endtask

    initial begin
        bit seen;
        reset_n = 0; start = 0; src_addr = 0; dst_addr = 0; length = 0;
        avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 0;
`ifdef MEMCOPY_FILL_EN
        fill_mode = 0; fill_pattern = 0;
`endif
        for (int i = 0; i < 32768; i++) mem[i] = 32'h5500_0000 + i;
        for (int i = 0; i < 10; i++) mem[i] = 32'hA000_0000 + i;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_req", 32'({avm_read, avm_write}), 32'h0);
        chk("reset_addr", 32'(avm_address), 32'h0);
        reset_n = 1;

        // Basic copy: chunks 4,4,2 -> 9+9+5 busy cycles.
        start_copy(15'h0, 15'h100, 16'd10, 1'b0, 32'h0);
        wait_done(200);
        chk("basic_first_busy", 32'(first_busy), 32'(t0 + 1));
        chk("basic_done_cyc", 32'(done_cyc), 32'(t0 + 24));
        chk("basic_busy_cycles", 32'(busy_cycles), 32'd23);
        chk("basic_reads", 32'(rd_count), 32'd10);
        chk("basic_writes", 32'(wr_count), 32'd10);
        chk("basic_done_count", 32'(done_count), 32'd1);
        chk("basic_mem100", mem[15'h100], 32'hA000_0000);
        chk("basic_mem109", mem[15'h109], 32'hA000_0009);

        // Zero length.
        start_copy(15'h5, 15'h500, 16'd0, 1'b0, 32'h0);
        wait_done(20);
        chk("zero_done_cyc", 32'(done_cyc), 32'(t0 + 1));
        chk("zero_busy", 32'(first_busy), 32'hFFFF_FFFF);
        chk("zero_traffic", 32'(rd_count + wr_count), 32'h0);
        chk("zero_done_count", 32'(done_count), 32'd1);

        // Stalls plus a start while busy, which must be ignored.
        stall_en = 1;
        start_copy(15'h40, 15'h400, 16'd7, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1 src_addr = 15'h1000; dst_addr = 15'h1100; length = 16'd3; start = 1;
        @(posedge clk); #1 start = 0;
        wait_done(400);
        stall_en = 0;
        chk("stall_reads", 32'(rd_count), 32'd7);
        chk("stall_writes", 32'(wr_count), 32'd7);
        chk("stall_done_count", 32'(done_count), 32'd1);
        chk("stall_mem406", mem[15'h406], 32'h5500_0046);

        // Address wrap on the source side.
        start_copy(15'h7FFE, 15'h10, 16'd4, 1'b0, 32'h0);
        wait_done(100);
        chk("wrap_mem10", mem[15'h10], 32'h5500_7FFE);
        chk("wrap_mem11", mem[15'h11], 32'h5500_7FFF);
        chk("wrap_mem12", mem[15'h12], 32'hA000_0000);
        chk("wrap_mem13", mem[15'h13], 32'hA000_0001);

        // Reset in WRITE, stale readdatavalid afterwards, then a fresh copy.
        start_copy(15'h60, 15'h600, 16'd8, 1'b0, 32'h0);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (avm_write) seen = 1;
        end
        chk("rst_saw_write", 32'(seen), 32'h1);
        #1 reset_n = 0;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_req", 32'({avm_read, avm_write, done}), 32'h0);
        chk("rst_addr", 32'(avm_address), 32'h0);
        chk("rst_be_wdata", 32'(avm_byteenable) | avm_writedata, 32'h0);
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1; inject_rdv = 1;
        repeat (3) @(posedge clk);
        start_copy(15'h70, 15'h700, 16'd2, 1'b0, 32'h0);
        wait_done(50);
        chk("rst_new_writes", 32'(wr_count), 32'd2);
        chk("rst_mem700", mem[15'h700], 32'h5500_0070);
        chk("rst_mem701", mem[15'h701], 32'h5500_0071);

`ifdef MEMCOPY_FILL_EN
        start_copy(15'h50, 15'h200, 16'd5, 1'b1, 32'hDEAD_BEEF);
        wait_done(50);
        chk("fill_reads", 32'(rd_count), 32'd0);
        chk("fill_writes", 32'(wr_count), 32'd5);
        chk("fill_done_count", 32'(done_count), 32'd1);
        chk("fill_mem204", mem[15'h204], 32'hDEAD_BEEF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
